// File: rtl/catch_egg_engine.sv
// catch_egg_engine: catch-the-egg game core (bucket, falling egg, score, lives) driving a row-scanned,
// active-low LED matrix. Optional macro SPEEDUP_EN shortens the egg step period as SCORE grows.
module catch_egg_engine #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int BUCKET_W    = 2,
    parameter int TICK_PERIOD = 4000000,
    parameter int SCAN_W      = 10,
    parameter int LIVES_INIT  = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            BTN_1,
    input  logic            BTN_2,
    input  logic            BTN_RST,
    output logic [COLS-1:0] LED_R,
    output logic [ROWS-1:0] LED_C,
    output logic [7:0]      SCORE,
    output logic [1:0]      LIVES,
    output logic [1:0]      STATE
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(TICK_PERIOD + 1);

    localparam logic [CW-1:0]   BPOS_MAX    = CW'(COLS - BUCKET_W);
    localparam logic [CW-1:0]   BPOS_INIT   = CW'((COLS - BUCKET_W) / 2);
    localparam logic [RW-1:0]   LAND_ROW    = RW'(ROWS - 2);
    localparam logic [RW-1:0]   BOTTOM_ROW  = RW'(ROWS - 1);
    localparam logic [COLS-1:0] BUCKET_ONES = COLS'((1 << BUCKET_W) - 1);
    localparam logic [15:0]     LFSR_SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] bpos_q, bpos_d;
    logic          egg_v_q, egg_v_d;
    logic [RW-1:0] egg_row_q, egg_row_d;
    logic [CW-1:0] egg_col_q, egg_col_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] tick_q, tick_d;

    logic [2:0]    sync1, sync2, hist, press;
    logic [TW-1:0] period;
    logic          tick;
    logic          in_bucket;
    logic [CW-1:0] spawn_col;
    logic          lfsr_fb;

    logic [SCAN_W-1:0] scan_lo;
    logic [RW-1:0]     scan_row;
    logic [COLS-1:0]   row_bits;

    // Buttons are active-low; bit 0 = BTN_1 (right), bit 1 = BTN_2 (left), bit 2 = BTN_RST.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            press <= '0;
        end else begin
            sync1 <= ~{BTN_RST, BTN_2, BTN_1};
            sync2 <= sync1;
            hist  <= sync2;
            press <= sync2 & ~hist;
        end
    end

    always_comb begin
`ifdef SPEEDUP_EN
        logic [1:0] shift;
        shift  = (score_q[7:4] > 4'd3) ? 2'd3 : score_q[5:4];
        period = TW'(TICK_PERIOD) >> shift;
        if (period == '0) begin
            period = TW'(1);
        end
`else
        period = TW'(TICK_PERIOD);
`endif
    end

    assign tick      = (state_q == S_PLAY) && (tick_q >= period - 1'b1);
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign spawn_col = CW'(int'(lfsr_q[3:0]) % COLS);
    assign in_bucket = (int'(egg_col_q) >= int'(bpos_q)) &&
                       (int'(egg_col_q) < int'(bpos_q) + BUCKET_W);

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        bpos_d    = bpos_q;
        egg_v_d   = egg_v_q;
        egg_row_d = egg_row_q;
        egg_col_d = egg_col_q;
        lfsr_d    = lfsr_q;
        tick_d    = tick_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (press[2]) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    lives_d = 2'(LIVES_INIT);
                    bpos_d  = BPOS_INIT;
                    egg_v_d = 1'b0;
                    tick_d  = '0;
                end
            end
            S_PLAY: begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (press[0] && !press[1] && bpos_q != BPOS_MAX) begin
                    bpos_d = bpos_q + 1'b1;
                end else if (press[1] && !press[0] && bpos_q != '0) begin
                    bpos_d = bpos_q - 1'b1;
                end
                if (tick) begin
                    lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                    if (!egg_v_q) begin
                        egg_v_d   = 1'b1;
                        egg_row_d = '0;
                        egg_col_d = spawn_col;
                    end else if (egg_row_q != LAND_ROW) begin
                        egg_row_d = egg_row_q + 1'b1;
                    end else begin
                        // Landing is judged against bpos_q, i.e. before any move in this same cycle.
                        egg_v_d = 1'b0;
                        if (in_bucket) begin
                            if (score_q != 8'hFF) begin
                                score_d = score_q + 8'd1;
                            end
                        end else begin
                            lives_d = lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state_d = S_OVER;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            lives_q   <= '0;
            bpos_q    <= BPOS_INIT;
            egg_v_q   <= 1'b0;
            egg_row_q <= '0;
            egg_col_q <= '0;
            lfsr_q    <= LFSR_SEED;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            bpos_q    <= bpos_d;
            egg_v_q   <= egg_v_d;
            egg_row_q <= egg_row_d;
            egg_col_q <= egg_col_d;
            lfsr_q    <= lfsr_d;
            tick_q    <= tick_d;
        end
    end

    // Pattern of the row currently being scanned, before active-low inversion.
    always_comb begin
        row_bits = '0;
        if (state_q == S_PLAY) begin
            if (scan_row == BOTTOM_ROW) begin
                row_bits = BUCKET_ONES << bpos_q;
            end else if (egg_v_q && egg_row_q == scan_row) begin
                row_bits = COLS'(1) << egg_col_q;
            end
        end else if (state_q == S_OVER && scan_row == BOTTOM_ROW) begin
            row_bits = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            scan_lo  <= '0;
            scan_row <= '0;
            LED_R    <= '1;
            LED_C    <= '1;
        end else begin
            scan_lo <= scan_lo + 1'b1;
            if (&scan_lo) begin
                scan_row <= (scan_row == BOTTOM_ROW) ? '0 : scan_row + 1'b1;
            end
            LED_R <= ~row_bits;
            LED_C <= ~(ROWS'(1) << scan_row);
        end
    end

    assign SCORE = score_q;
    assign LIVES = lives_q;
    assign STATE = state_q;

endmodule

// File: doc/catch_egg_engine.md
# catch_egg_engine

Parametrised game core for the LED-matrix "catch the egg" board: one falling egg per round in a COLS×ROWS matrix, a multi-column bucket on the bottom row, a score counter, a lives counter, and a start/play/over state machine. Also drives the row-scanned, active-low LED matrix. Sits between the board push-buttons and the LED pins, replacing the fixed 8×4, single-life, no-score game logic.

## Interface
- COLS, 8, matrix columns (2..16); LED_R width.
- ROWS, 4, matrix rows (2..8); the egg falls through rows 0..ROWS-2, the bucket occupies row ROWS-1.
- BUCKET_W, 2, bucket width in columns (1..COLS-1).
- TICK_PERIOD, 4000000, clock cycles per egg step (≥4).
- SCAN_W, 10, log2 of cycles each matrix row is driven.
- LIVES_INIT, 3, lives loaded at game start (1..3).
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous reset, active-low.
- BTN_1  in  1  move-right button, raw, active-low.
- BTN_2  in  1  move-left button, raw, active-low.
- BTN_RST  in  1  start/restart button, raw, active-low.
- LED_R  out  COLS  column pattern of the scanned row, active-low; bit i = column i.
- LED_C  out  ROWS  row select, active-low one-hot.
- SCORE  out  8  eggs caught, saturates at 255.
- LIVES  out  2  lives remaining.
- STATE  out  2  0=IDLE, 1=PLAY, 2=OVER.

## Operation
- Reset (RST_N=0 at a posedge): STATE=IDLE, SCORE=0, LIVES=0, LED_R all 1, LED_C all 1, no egg, LFSR=16'hACE1, tick and scan counters 0.
- Buttons: each passes through 2 sync flops and 1 history flop; a press is a one-cycle pulse on the synchronised 0→1 "pressed" transition. No repeat while held.
- IDLE: matrix blank. A BTN_RST press moves to PLAY and initialises: SCORE=0, LIVES=LIVES_INIT, BPOS=(COLS-BUCKET_W)/2 (floor), no egg, tick counter=0.
- PLAY:
  - Bucket occupies columns BPOS..BPOS+BUCKET_W-1. A BTN_1 press does BPOS+1 unless BPOS=COLS-BUCKET_W. A BTN_2 press does BPOS-1 unless BPOS=0. Simultaneous BTN_1 and BTN_2 presses: no move.
  - Tick pulse: fires when the tick counter reaches period-1, then the counter wraps to 0.
  - On a tick with no egg: spawn at row 0, column = LFSR[3:0] mod COLS.
  - On a tick with the egg in rows 0..ROWS-3: egg row +1.
  - On a tick with the egg in row ROWS-2 (landing): judge the column against the BPOS registered before this cycle's move. Inside the bucket → SCORE+1 (saturating). Otherwise LIVES-1. Either way the egg is cleared, so the next tick spawns a new egg.
  - Landing miss with LIVES=1 → LIVES=0, STATE=OVER.
  - BTN_RST presses in PLAY are ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per tick in PLAY only, so spawn sequences are repeatable.
- OVER: row ROWS-1 is fully lit, all other rows blank. SCORE is held. A BTN_RST press re-initialises as from IDLE. The LFSR is not reseeded.
- Scan:
  - Row index = scan counter bits above SCAN_W; wraps at ROWS (non-power-of-two ROWS wrap explicitly).
  - LED_C = ~(1<<row).
  - LED_R = ~(bucket mask for row ROWS-1, egg mask for the egg's row, 0 otherwise).
  - The scan runs in all states, including IDLE.

## Timing
- Button pin fall → press pulse: 3 cycles. Pulse cycle → BPOS, state or counter update visible: 1 cycle.
- Tick → egg, SCORE, LIVES, STATE update: registered at the tick edge, visible the next cycle.
- First tick after entering PLAY: TICK_PERIOD cycles later.
- Matrix state → LED_R/LED_C: 1 registered cycle.
- Each row is driven for 2^SCAN_W cycles.
- Scan wrap: after row ROWS-1, the next row is 0.
- Same-cycle BTN_1/BTN_2 press and landing tick: the judgement uses the old BPOS, and the move still applies.
- Reset mid-game: all state returns to reset values in the same cycle; a press pulse in flight is discarded.

## Configuration
- SPEEDUP_EN defined: effective tick period = TICK_PERIOD >> min(SCORE[7:4], 3). The new period applies from the tick after the SCORE update.
- SPEEDUP_EN undefined: period is fixed at TICK_PERIOD; no shifter is present.

## Test plan
Sim parameters: TICK_PERIOD=16, SCAN_W=2, COLS=8, ROWS=4, BUCKET_W=2.
- Reset, then BTN_RST press → STATE=1 four cycles after the pin falls; LIVES=3, SCORE=0, BPOS=3; bottom row LED_R=8'hE7.
- Five BTN_1 presses from BPOS=3 → BPOS=6 then held at 6. Seven BTN_2 presses → BPOS=0. Simultaneous BTN_1 and BTN_2 press → BPOS unchanged.
- Force egg column = BPOS → at landing SCORE 0→1, LIVES=3. Force an out-of-bucket column → LIVES 3→2.
- Three misses → STATE=2, row 3 shows LED_R=8'h00, SCORE held. Next BTN_RST press → STATE=1, LIVES=3.
- RST_N low mid-fall → LED_R=8'hFF, LED_C=4'hF, STATE=0 the next cycle.
- SPEEDUP_EN with SCORE forced to 16, then 48 → measured tick spacing 8, then 2 cycles.
